rgb_pixel_fifo: RTL and testbench

RGB_PIXEL_FIFO -- requirements
Module: rgb_pixel_fifo

---
 rtl/rgb_pixel_fifo.sv | 90 +++++++++
 tb/tb_rgb_pixel_fifo.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pixel_fifo.sv
// rtl/rgb_pixel_fifo.sv - RGB pixel FIFO with first-word fall-through head
//
// Ports:
//   clk                    single clock, rising edge
//   reset                  synchronous, active-high
//   uin_r/uin_g/uin_b      incoming pixel components (8 bits each)
//   uin_valid, uin_ready   upstream handshake; push when both are high
//   uout_r/uout_g/uout_b   head pixel components, 8'h0 when nothing is held
//   uout_valid, uout_ready downstream handshake; pop when both are high
//   level                  occupancy, only when RGB_FIFO_LEVEL_EN is defined
//
// Optional feature macro: RGB_FIFO_LEVEL_EN (adds the level output).
module rgb_pixel_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               uin_r,
  input  logic [7:0]               uin_g,
  input  logic [7:0]               uin_b,
  input  logic                     uin_valid,
  output logic                     uin_ready,
  output logic [7:0]               uout_r,
  output logic [7:0]               uout_g,
  output logic [7:0]               uout_b,
  output logic                     uout_valid,
  input  logic                     uout_ready
`ifdef RGB_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]   level
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem_r [DEPTH];
  logic [7:0]    mem_g [DEPTH];
  logic [7:0]    mem_b [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  // Both handshake flags decode registered state only; reset masks them so
  // nothing is offered or accepted while the block is being cleared.
  assign uin_ready  = !reset && (count < FULL_COUNT);
  assign uout_valid = !reset && (count != '0);

  assign push = uin_valid && uin_ready;
  assign pop  = uout_valid && uout_ready;

  // Head pixel falls through from storage; forced to zero when empty so
  // stale storage contents never leak downstream.
  assign uout_r = uout_valid ? mem_r[rd_ptr] : 8'h0;
  assign uout_g = uout_valid ? mem_g[rd_ptr] : 8'h0;
  assign uout_b = uout_valid ? mem_b[rd_ptr] : 8'h0;

  // Storage needs no reset; entries are only observable once counted.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr] <= uin_r;
      mem_g[wr_ptr] <= uin_g;
      mem_b[wr_ptr] <= uin_b;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef RGB_FIFO_LEVEL_EN
  assign level = count;
`endif

endmodule

// File: tb/tb_rgb_pixel_fifo.sv
// tb/tb_rgb_pixel_fifo.sv - self-checking bench for rgb_pixel_fifo
module tb_rgb_pixel_fifo;

  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic [7:0] uin_r, uin_g, uin_b;
  logic       uin_valid;
  logic       uin_ready;
  logic [7:0] uout_r, uout_g, uout_b;
  logic       uout_valid;
  logic       uout_ready;
`ifdef RGB_FIFO_LEVEL_EN
  logic [$clog2(DEPTH):0] level;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: ordered list of stored pixels as {r,g,b}.
  logic [23:0] q[$];

  rgb_pixel_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .uin_r      (uin_r),
    .uin_g      (uin_g),
    .uin_b      (uin_b),
    .uin_valid  (uin_valid),
    .uin_ready  (uin_ready),
    .uout_r     (uout_r),
    .uout_g     (uout_g),
    .uout_b     (uout_b),
    .uout_valid (uout_valid),
    .uout_ready (uout_ready)
`ifdef RGB_FIFO_LEVEL_EN
    ,
    .level      (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge, applying the FIFO rules to the model, then settle.
  task automatic tick();
    bit do_push, do_pop;
    do_push = !reset && uin_valid && (q.size() < DEPTH);
    do_pop  = !reset && uout_ready && (q.size() > 0);
    @(posedge clk);
    if (reset) begin
      q.delete();
    end else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back({uin_r, uin_g, uin_b});
    end
    #1;
  endtask

  task automatic set_pixel(input logic [23:0] p);
    {uin_r, uin_g, uin_b} = p;
  endtask

  task automatic test_reset();
    reset = 1'b1; uin_valid = 1'b1; uout_ready = 1'b1; set_pixel(24'h777777);
    tick();
    tick();
    checks++;
    if (uin_ready !== 1'b0) begin errors++; $display("FAIL reset_uin_ready got %b want 0", uin_ready); end
    checks++;
    if (uout_valid !== 1'b0) begin errors++; $display("FAIL reset_uout_valid got %b want 0", uout_valid); end
    checks++;
    if ({uout_r, uout_g, uout_b} !== 24'h0) begin errors++; $display("FAIL reset_data got %h want 000000", {uout_r, uout_g, uout_b}); end
`ifdef RGB_FIFO_LEVEL_EN
    checks++;
    if (level !== '0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
`endif
    reset = 1'b0; uin_valid = 1'b0; uout_ready = 1'b0;
    #1;
    checks++;
    if (uin_ready !== 1'b1) begin errors++; $display("FAIL post_reset_uin_ready got %b want 1", uin_ready); end
  endtask

  task automatic test_single();
    uin_valid = 1'b1; uout_ready = 1'b0; set_pixel(24'h112233);
    tick();
    uin_valid = 1'b0;
    checks++;
    if (uout_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", uout_valid); end
    checks++;
    if ({uout_r, uout_g, uout_b} !== 24'h112233) begin errors++; $display("FAIL single_data got %h want 112233", {uout_r, uout_g, uout_b}); end
`ifdef RGB_FIFO_LEVEL_EN
    checks++;
    if (level !== 1) begin errors++; $display("FAIL single_level got %0d want 1", level); end
`endif
    uout_ready = 1'b1;
    tick();
    uout_ready = 1'b0;
    checks++;
    if (uout_valid !== 1'b0 || {uout_r, uout_g, uout_b} !== 24'h0) begin
      errors++; $display("FAIL single_drain got valid %b data %h want 0/000000", uout_valid, {uout_r, uout_g, uout_b});
    end
  endtask

  task automatic test_full();
    uout_ready = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      uin_valid = 1'b1; set_pixel({3{8'(i)}});
      checks++;
      if (uin_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got %b want 1", i, uin_ready); end
      tick();
    end
    checks++;
    if (uin_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", uin_ready); end
    set_pixel(24'h050505);
    tick();
    uin_valid = 1'b0;
    checks++;
    if (q.size() != DEPTH || {uout_r, uout_g, uout_b} !== 24'h010101 || uin_ready !== 1'b0) begin
      errors++; $display("FAIL full_hold got data %h ready %b want 010101/0", {uout_r, uout_g, uout_b}, uin_ready);
    end
`ifdef RGB_FIFO_LEVEL_EN
    checks++;
    if (level !== DEPTH) begin errors++; $display("FAIL full_level got %0d want %0d", level, DEPTH); end
`endif
  endtask

  task automatic test_drain();
    uout_ready = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      checks++;
      if (uout_valid !== 1'b1 || {uout_r, uout_g, uout_b} !== {3{8'(i)}}) begin
        errors++; $display("FAIL drain_%0d got valid %b data %h want 1/%h", i, uout_valid, {uout_r, uout_g, uout_b}, {3{8'(i)}});
      end
      tick();
    end
    uout_ready = 1'b0;
    checks++;
    if (uout_valid !== 1'b0 || {uout_r, uout_g, uout_b} !== 24'h0) begin
      errors++; $display("FAIL drain_empty got valid %b data %h want 0/000000", uout_valid, {uout_r, uout_g, uout_b});
    end
  endtask

  task automatic test_back_to_back();
    uin_valid = 1'b1; uout_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_pixel({3{8'(8'h10 + i)}});
      if (i > 0) begin
        checks++;
        if (uout_valid !== 1'b1 || {uout_r, uout_g, uout_b} !== {3{8'(8'h10 + i - 1)}} || uin_ready !== 1'b1) begin
          errors++; $display("FAIL b2b_%0d got valid %b data %h ready %b want 1/%h/1",
                             i, uout_valid, {uout_r, uout_g, uout_b}, uin_ready, {3{8'(8'h10 + i - 1)}});
        end
`ifdef RGB_FIFO_LEVEL_EN
        checks++;
        if (level !== 1) begin errors++; $display("FAIL b2b_level_%0d got %0d want 1", i, level); end
`endif
      end
      tick();
    end
    uin_valid = 1'b0;
    checks++;
    if ({uout_r, uout_g, uout_b} !== 24'h191919) begin errors++; $display("FAIL b2b_last got %h want 191919", {uout_r, uout_g, uout_b}); end
    tick();
    uout_ready = 1'b0;
    checks++;
    if (uout_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b want 0", uout_valid); end
  endtask

  task automatic test_reset_midstream();
    uout_ready = 1'b0; uin_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_pixel({3{8'(8'h30 + i)}});
      tick();
    end
    reset = 1'b1; set_pixel(24'h555555);
    tick();
    reset = 1'b0; uin_valid = 1'b0;
    #1;
    checks++;
    if (uout_valid !== 1'b0 || uin_ready !== 1'b1) begin
      errors++; $display("FAIL midreset got valid %b ready %b want 0/1", uout_valid, uin_ready);
    end
`ifdef RGB_FIFO_LEVEL_EN
    checks++;
    if (level !== '0) begin errors++; $display("FAIL midreset_level got %0d want 0", level); end
`endif
    uin_valid = 1'b1; set_pixel(24'hAAAAAA);
    tick();
    uin_valid = 1'b0;
    checks++;
    if (uout_valid !== 1'b1 || {uout_r, uout_g, uout_b} !== 24'hAAAAAA) begin
      errors++; $display("FAIL midreset_first got valid %b data %h want 1/aaaaaa", uout_valid, {uout_r, uout_g, uout_b});
    end
    uout_ready = 1'b1;
    tick();
    uout_ready = 1'b0;
  endtask

  task automatic test_random();
    int local_err = 0;
    for (int c = 0; c < 1000; c++) begin
      uin_valid  = $urandom_range(0, 1) == 1;
      uout_ready = $urandom_range(0, 1) == 1;
      set_pixel(24'($urandom));
      #1;
      checks++;
      if (uin_ready !== (q.size() < DEPTH) || uout_valid !== (q.size() > 0) ||
          {uout_r, uout_g, uout_b} !== ((q.size() > 0) ? q[0] : 24'h0)) begin
        errors++;
        if (local_err < 10)
          $display("FAIL random_%0d got ready %b valid %b data %h want %b/%b/%h", c, uin_ready, uout_valid,
                   {uout_r, uout_g, uout_b}, q.size() < DEPTH, q.size() > 0, (q.size() > 0) ? q[0] : 24'h0);
        local_err++;
      end
`ifdef RGB_FIFO_LEVEL_EN
      checks++;
      if (level !== q.size()) begin errors++; $display("FAIL random_level_%0d got %0d want %0d", c, level, q.size()); end
`endif
      tick();
    end
    uin_valid = 1'b0; uout_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; uin_valid = 1'b0; uout_ready = 1'b0; set_pixel(24'h0);
    test_reset();
    test_single();
    test_full();
    test_drain();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
